// File: rtl/vx_fetch.sv
// vx_fetch: fetch stage behind the warp scheduler. Registers one I-cache request per cycle,
// parks warp metadata in a per-warp table, and re-joins it with the returned instruction word
// in a 2-entry output FIFO. Responses may arrive out of order across warps.
module vx_fetch #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned UUID_WIDTH  = 44,
  localparam int unsigned NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sched_valid,
  input  logic [NW_WIDTH-1:0]    sched_wid,
  input  logic [NUM_THREADS-1:0] sched_tmask,
  input  logic [XLEN-1:0]        sched_pc,
  input  logic [UUID_WIDTH-1:0]  sched_uuid,
  output logic                   sched_ready,
  output logic                   icache_req_valid,
  output logic [XLEN-3:0]        icache_req_addr,
  output logic [NW_WIDTH-1:0]    icache_req_tag,
  input  logic                   icache_req_ready,
  input  logic                   icache_rsp_valid,
  input  logic [31:0]            icache_rsp_data,
  input  logic [NW_WIDTH-1:0]    icache_rsp_tag,
  output logic                   icache_rsp_ready,
  output logic                   fetch_valid,
  output logic [NW_WIDTH-1:0]    fetch_wid,
  output logic [NUM_THREADS-1:0] fetch_tmask,
  output logic [XLEN-1:0]        fetch_pc,
  output logic [UUID_WIDTH-1:0]  fetch_uuid,
  output logic [31:0]            fetch_instr,
  input  logic                   fetch_ready,
  output logic [NUM_WARPS-1:0]   pending_mask,
  output logic                   tag_err,
  output logic                   busy
);

  localparam int unsigned META_W  = NUM_THREADS + XLEN + UUID_WIDTH;
  localparam int unsigned ENTRY_W = NW_WIDTH + META_W + 32;

  logic                 req_vld_q;
  logic [XLEN-3:0]      req_addr_q;
  logic [NW_WIDTH-1:0]  req_tag_q;
  logic [NUM_WARPS-1:0] pending_q, pending_d;
  logic                 tag_err_q;
  logic [META_W-1:0]    meta_q [NUM_WARPS];
  logic [ENTRY_W-1:0]   fifo_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           cnt_q;

  logic               sched_fire, rsp_fire, pop, fifo_empty, fifo_full, rsp_pending;
  logic [ENTRY_W-1:0] push_entry;
  logic               unused_pc_lsb;

  // PC byte offset is dropped: requests are word addresses.
  assign unused_pc_lsb = ^sched_pc[1:0];

  assign sched_ready      = ~req_vld_q | icache_req_ready;
  assign sched_fire       = sched_valid & sched_ready;
  assign fifo_empty       = (cnt_q == 2'd0);
  assign fifo_full        = (cnt_q == 2'd2);
  assign fetch_valid      = ~fifo_empty;
  assign pop              = fetch_valid & fetch_ready;
  // A full FIFO still takes a response when the head leaves in the same cycle.
  assign icache_rsp_ready = ~fifo_full | fetch_ready;
  assign rsp_fire         = icache_rsp_valid & icache_rsp_ready;
  assign rsp_pending      = pending_q[icache_rsp_tag];

  // Table read sees the pre-edge entry, so a same-cycle rewrite of that warp cannot leak in.
  assign push_entry = {icache_rsp_tag, meta_q[icache_rsp_tag], icache_rsp_data};

  assign icache_req_valid = req_vld_q;
  assign icache_req_addr  = req_addr_q;
  assign icache_req_tag   = req_tag_q;
  assign {fetch_wid, fetch_tmask, fetch_pc, fetch_uuid, fetch_instr} = fifo_q[rd_ptr_q];
  assign pending_mask     = pending_q;
  assign tag_err          = tag_err_q;
  assign busy             = (|pending_q) | req_vld_q | ~fifo_empty;

  // Request register: loads on accept, drains when the I-cache takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_vld_q  <= 1'b0;
      req_addr_q <= '0;
      req_tag_q  <= '0;
    end else if (sched_fire) begin
      req_vld_q  <= 1'b1;
      req_addr_q <= sched_pc[XLEN-1:2];
      req_tag_q  <= sched_wid;
    end else if (icache_req_ready) begin
      req_vld_q  <= 1'b0;
    end
  end

  // Per-warp metadata; never read for a warp that was not accepted, so left unreset.
  always_ff @(posedge clk) begin
    if (sched_fire) meta_q[sched_wid] <= {sched_tmask, sched_pc, sched_uuid};
  end

  // Response retires the old fetch first; a same-cycle accept of that warp sets it again.
  always_comb begin
    pending_d = pending_q;
    if (rsp_fire)   pending_d[icache_rsp_tag] = 1'b0;
    if (sched_fire) pending_d[sched_wid]      = 1'b1;
  end

  // Pending mask and sticky tag error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      tag_err_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (rsp_fire && !rsp_pending) tag_err_q <= 1'b1;
    end
  end

  // Two-entry output FIFO in response-arrival order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (rsp_fire) begin
        fifo_q[wr_ptr_q] <= push_entry;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, rsp_fire} - {1'b0, pop};
    end
  end

  // Scheduler must not re-issue a warp while its fetch is in flight, unless that warp's
  // response retires the old fetch in the same cycle.
  a_no_double_issue: assert property (@(posedge clk) disable iff (!reset_n)
    sched_fire |-> (!pending_q[sched_wid] || (rsp_fire && (icache_rsp_tag == sched_wid))));

endmodule

// File: tb/tb_vx_fetch.sv
// tb_vx_fetch: directed scenarios followed by a random phase, all checked against a
// queue-based reference model of the fetch stage.
module tb_vx_fetch;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        sched_valid;
  logic [1:0]  sched_wid;
  logic [3:0]  sched_tmask;
  logic [31:0] sched_pc;
  logic [43:0] sched_uuid;
  logic        sched_ready;
  logic        icache_req_valid;
  logic [29:0] icache_req_addr;
  logic [1:0]  icache_req_tag;
  logic        icache_req_ready;
  logic        icache_rsp_valid;
  logic [31:0] icache_rsp_data;
  logic [1:0]  icache_rsp_tag;
  logic        icache_rsp_ready;
  logic        fetch_valid;
  logic [1:0]  fetch_wid;
  logic [3:0]  fetch_tmask;
  logic [31:0] fetch_pc;
  logic [43:0] fetch_uuid;
  logic [31:0] fetch_instr;
  logic        fetch_ready;
  logic [3:0]  pending_mask;
  logic        tag_err;
  logic        busy;

  always #5 clk = ~clk;

  vx_fetch #(.NUM_WARPS(4), .NUM_THREADS(4), .XLEN(32), .UUID_WIDTH(44)) dut (
    .clk(clk), .reset_n(reset_n),
    .sched_valid(sched_valid), .sched_wid(sched_wid), .sched_tmask(sched_tmask),
    .sched_pc(sched_pc), .sched_uuid(sched_uuid), .sched_ready(sched_ready),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .icache_req_tag(icache_req_tag), .icache_req_ready(icache_req_ready),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_data(icache_rsp_data),
    .icache_rsp_tag(icache_rsp_tag), .icache_rsp_ready(icache_rsp_ready),
    .fetch_valid(fetch_valid), .fetch_wid(fetch_wid), .fetch_tmask(fetch_tmask),
    .fetch_pc(fetch_pc), .fetch_uuid(fetch_uuid), .fetch_instr(fetch_instr),
    .fetch_ready(fetch_ready), .pending_mask(pending_mask), .tag_err(tag_err), .busy(busy)
  );

  // Reference model state
  typedef struct {
    logic [1:0]  wid;
    logic [3:0]  tmask;
    logic [31:0] pc;
    logic [43:0] uuid;
    logic [31:0] instr;
  } ent_t;

  ent_t        outq[$];
  int          sent[$];
  logic [3:0]  m_tmask [NW];
  logic [31:0] m_pc    [NW];
  logic [43:0] m_uuid  [NW];
  bit          m_pend  [NW];
  bit          m_req_vld;
  logic [29:0] m_req_addr;
  logic [1:0]  m_req_tag;
  bit          m_tag_err;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_pmask();
    logic [3:0] m;
    for (int i = 0; i < NW; i++) m[i] = m_pend[i];
    return m;
  endfunction

  function automatic bit any_pend();
    bit a = 0;
    for (int i = 0; i < NW; i++) a |= m_pend[i];
    return a;
  endfunction

  task automatic model_reset();
    outq.delete();
    for (int i = 0; i < NW; i++) m_pend[i] = 0;
    m_req_vld = 0;
    m_tag_err = 0;
  endtask

  task automatic idle();
    sched_valid = 0; sched_wid = 0; sched_tmask = 0; sched_pc = 0; sched_uuid = 0;
    icache_req_ready = 1; icache_rsp_valid = 0; icache_rsp_data = 0; icache_rsp_tag = 0;
    fetch_ready = 1;
  endtask

  task automatic sched(input int w, input logic [31:0] pc, input logic [3:0] tm,
                       input logic [43:0] uu);
    sched_valid = 1; sched_wid = w[1:0]; sched_pc = pc; sched_tmask = tm; sched_uuid = uu;
  endtask

  task automatic rsp(input int tag, input logic [31:0] data);
    icache_rsp_valid = 1; icache_rsp_tag = tag[1:0]; icache_rsp_data = data;
  endtask

  task automatic settle_check();
    bit exp_rr;
    #1;
    exp_rr = (outq.size() < 2) || fetch_ready;
    chk("sched_ready", sched_ready, !m_req_vld || icache_req_ready);
    chk("icache_req_valid", icache_req_valid, m_req_vld);
    if (m_req_vld) begin
      chk("icache_req_addr", icache_req_addr, m_req_addr);
      chk("icache_req_tag", icache_req_tag, m_req_tag);
    end
    chk("icache_rsp_ready", icache_rsp_ready, exp_rr);
    chk("fetch_valid", fetch_valid, outq.size() != 0);
    if (outq.size() != 0) begin
      chk("fetch_wid", fetch_wid, outq[0].wid);
      chk("fetch_tmask", fetch_tmask, outq[0].tmask);
      chk("fetch_pc", fetch_pc, outq[0].pc);
      chk("fetch_uuid", fetch_uuid, outq[0].uuid);
      chk("fetch_instr", fetch_instr, outq[0].instr);
    end
    chk("pending_mask", pending_mask, exp_pmask());
    chk("tag_err", tag_err, m_tag_err);
    chk("busy", busy, any_pend() || m_req_vld || outq.size() != 0);
  endtask

  // Advance one clock and apply the transfer rules to the model.
  task automatic tick();
    bit acc, rf, pop, reqfire;
    int w, sw, idx;
    ent_t e;
    acc     = sched_valid && (!m_req_vld || icache_req_ready);
    rf      = icache_rsp_valid && ((outq.size() < 2) || fetch_ready);
    pop     = (outq.size() != 0) && fetch_ready;
    reqfire = m_req_vld && icache_req_ready;
    w       = int'(icache_rsp_tag);
    sw      = int'(sched_wid);
    @(posedge clk);
    if (pop) void'(outq.pop_front());
    if (rf) begin
      e.wid = w[1:0]; e.tmask = m_tmask[w]; e.pc = m_pc[w]; e.uuid = m_uuid[w];
      e.instr = icache_rsp_data;
      outq.push_back(e);
      if (!m_pend[w]) m_tag_err = 1;
      m_pend[w] = 0;
      idx = -1;
      for (int i = 0; i < sent.size(); i++) if (idx < 0 && sent[i] == w) idx = i;
      if (idx >= 0) sent.delete(idx);
    end
    if (reqfire) sent.push_back(int'(m_req_tag));
    if (acc) begin
      m_pend[sw] = 1;
      m_tmask[sw] = sched_tmask; m_pc[sw] = sched_pc; m_uuid[sw] = sched_uuid;
      m_req_vld = 1; m_req_addr = sched_pc[31:2]; m_req_tag = sched_wid;
    end else if (icache_req_ready) begin
      m_req_vld = 0;
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    settle_check();
    tick();
  endtask

  initial begin
    logic [63:0] r;
    int free[$];
    idle();
    model_reset();
    #1 reset_n = 0;
    settle_check();
    @(negedge clk);
    reset_n = 1;

    // Single fetch
    idle(); sched(1, 32'h8000_0000, 4'b0001, 44'h000_0000_0101); cycle();
    idle(); settle_check();
    chk("t1_req_addr", icache_req_addr, 30'h2000_0000);
    chk("t1_req_tag", icache_req_tag, 2'd1);
    tick();
    idle(); cycle();
    rsp(1, 32'h0000_0013); cycle();
    idle(); settle_check();
    chk("t1_instr", fetch_instr, 32'h0000_0013);
    chk("t1_pc", fetch_pc, 32'h8000_0000);
    tick();

    // Out-of-order return
    idle(); sched(0, 32'h0000_1000, 4'b1111, 44'h0AA_0000_0000); cycle();
    idle(); sched(1, 32'h0000_2004, 4'b0011, 44'h0BB_0000_0001); cycle();
    idle(); sched(2, 32'h0000_3008, 4'b0101, 44'h0CC_0000_0002); cycle();
    idle(); settle_check();
    chk("t2_pending", pending_mask, 4'b0111);
    tick();
    idle(); rsp(2, 32'h2222_0000); cycle();
    idle(); rsp(0, 32'h0000_0000); settle_check();
    chk("t2_first_out", fetch_wid, 2'd2);
    tick();
    idle(); rsp(1, 32'h1111_0000); cycle();
    idle(); cycle();
    idle(); settle_check();
    chk("t2_pending_clear", pending_mask, 4'b0000);
    tick();

    // Output backpressure
    idle(); sched(0, 32'h0000_4000, 4'b0001, 44'h1); cycle();
    idle(); sched(1, 32'h0000_5000, 4'b0010, 44'h2); cycle();
    idle(); sched(2, 32'h0000_6000, 4'b0100, 44'h3); cycle();
    idle(); cycle();
    idle(); fetch_ready = 0; rsp(0, 32'hA0); cycle();
    idle(); fetch_ready = 0; rsp(1, 32'hA1); cycle();
    idle(); fetch_ready = 0; rsp(2, 32'hA2); settle_check();
    chk("t3_rsp_ready_full", icache_rsp_ready, 1'b0);
    tick();
    idle(); fetch_ready = 0; rsp(2, 32'hA2); cycle();
    idle(); rsp(2, 32'hA2); cycle();
    for (int i = 0; i < 3; i++) begin idle(); cycle(); end

    // I-cache request stall
    idle(); icache_req_ready = 0; sched(3, 32'h0000_7770, 4'b1000, 44'h77); cycle();
    for (int i = 0; i < 5; i++) begin
      idle(); icache_req_ready = 0; sched(0, 32'h0000_9990, 4'b0001, 44'h99); settle_check();
      chk("t4_sched_stall", sched_ready, 1'b0);
      chk("t4_addr_hold", icache_req_addr, 30'h0000_1DDC);
      tick();
    end
    idle(); cycle();

    // Same-cycle accept and response for warp 3
    idle(); sched(3, 32'h0000_8880, 4'b1001, 44'h88); rsp(3, 32'h0000_0333); cycle();
    idle(); settle_check();
    chk("t5_old_pc", fetch_pc, 32'h0000_7770);
    chk("t5_pending3", pending_mask[3], 1'b1);
    tick();
    idle(); cycle();
    idle(); rsp(3, 32'h0000_0444); cycle();
    idle(); settle_check();
    chk("t5_new_pc", fetch_pc, 32'h0000_8880);
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      icache_req_ready = ($urandom_range(0, 3) != 0);
      fetch_ready      = ($urandom_range(0, 2) != 0);
      free.delete();
      for (int w = 0; w < NW; w++) if (!m_pend[w]) free.push_back(w);
      if (free.size() != 0 && $urandom_range(0, 1) == 1) begin
        r = {$urandom, $urandom};
        sched(free[$urandom_range(0, free.size() - 1)], $urandom, r[47:44], r[43:0]);
      end
      if (sent.size() != 0 && $urandom_range(0, 2) != 0)
        rsp(sent[$urandom_range(0, sent.size() - 1)], $urandom);
      cycle();
    end
    for (int n = 0; n < 30; n++) begin
      idle();
      if (sent.size() != 0) rsp(sent[0], $urandom);
      cycle();
    end
    chk("rand_drained_busy", busy, 1'b0);

    // Spurious response, then reset mid-flight
    idle(); rsp(2, 32'hDEAD_BEEF); cycle();
    idle(); settle_check();
    chk("t6_tag_err", tag_err, 1'b1);
    tick();
    idle(); sched(0, 32'h0000_A000, 4'b0001, 44'hA); cycle();
    idle(); sched(1, 32'h0000_B000, 4'b0010, 44'hB); cycle();
    idle(); icache_req_ready = 0; cycle();
    idle();
    reset_n = 0;
    #1;
    chk("t6_rst_req_valid", icache_req_valid, 1'b0);
    chk("t6_rst_fetch_valid", fetch_valid, 1'b0);
    chk("t6_rst_fetch_pc", fetch_pc, 32'h0);
    chk("t6_rst_pending", pending_mask, 4'b0000);
    chk("t6_rst_tag_err", tag_err, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    idle(); cycle();
    idle(); rsp(0, 32'h0000_0F0F); cycle();
    idle(); settle_check();
    chk("t6_late_tag_err", tag_err, 1'b1);
    tick();
    idle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
